// File: rtl/cp0_unit.sv
// CP0 exception/interrupt controller at M stage: SR/Cause/EPC/PRId, mfc0/mtc0, eret EPC return.
// req and DOut are combinational; register updates land on the next clk edge; no backpressure.
module cp0_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h2023_0711
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] M_PC,
  input  logic [4:0]  M_ExcCode,
  input  logic        M_isBD,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        unused_handler;

  // HANDLER_ADDR is consumed by the NPC logic, not here.
  assign unused_handler = ^HANDLER_ADDR;

  assign int_req = sr_ie & ~sr_exl & (|(HWInt & sr_im));
  assign exc_req = ~sr_exl & (M_ExcCode != 5'd0);
  assign req     = int_req | exc_req;
  assign EPCOut  = epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= HWInt;
      if (req) begin
        // The M-stage instruction is squashed, so its mtc0/eret effects are dropped.
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : M_ExcCode;
        cause_bd  <= M_isBD;
        epc       <= M_isBD ? (M_PC - 32'd4) : M_PC;
      end else begin
        if (WE && (A2 == 5'd12)) begin
          sr_im  <= DIn[15:10];
          sr_exl <= DIn[1];
          sr_ie  <= DIn[0];
        end
        if (WE && (A2 == 5'd14)) begin
          epc <= DIn;
        end
        // Placed after the SR write so eret wins on EXL when both occur together.
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (A1)
      5'd12:   DOut = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      5'd13:   DOut = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      5'd14:   DOut = epc;
      5'd15:   DOut = PRID_VALUE;
      default: DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios plus a randomized run against a register-level model.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2023_0711;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] M_PC;
  logic [4:0]  M_ExcCode;
  logic        M_isBD;
  logic        EXLClr;
  logic [5:0]  HWInt;
  logic        req;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  int errors = 0;
  int checks = 0;

  // Model state kept as architectural 32-bit register images.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .M_PC(M_PC), .M_ExcCode(M_ExcCode), .M_isBD(M_isBD), .EXLClr(EXLClr),
    .HWInt(HWInt), .req(req), .EPCOut(EPCOut), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_int();
    return m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic logic m_req();
    return m_int() || (!m_sr[1] && (M_ExcCode != 5'd0));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    case (idx)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_clear();
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
  endtask

  task automatic m_update();
    logic [31:0] ns, nc, ne;
    ns = m_sr; nc = m_cause; ne = m_epc;
    nc[15:10] = HWInt;
    if (m_req()) begin
      ns[1]   = 1'b1;
      nc[6:2] = m_int() ? 5'd0 : M_ExcCode;
      nc[31]  = M_isBD;
      ne      = M_isBD ? M_PC - 32'd4 : M_PC;
    end else begin
      if (WE && A2 == 5'd12) ns = DIn & 32'h0000_FC03;
      if (WE && A2 == 5'd14) ne = DIn;
      if (EXLClr) ns[1] = 1'b0;
    end
    m_sr = ns; m_cause = nc; m_epc = ne;
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; A2 = 5'd0; DIn = 32'd0; M_PC = 32'h0000_3000; M_ExcCode = 5'd0;
    M_isBD = 1'b0; EXLClr = 1'b0; HWInt = 6'd0; A1 = 5'd0;
  endtask

  task automatic mtc0(input logic [4:0] idx, input logic [31:0] val);
    WE = 1'b1; A2 = idx; DIn = val;
    tick();
    WE = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    m_clear();
    #12;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 12; i <= 15; i++) begin
      A1 = 5'(i);
      #1;
      checks++;
      if (DOut !== ((i == 15) ? PRID : 32'd0)) begin
        errors++;
        $display("FAIL reset_dout A1=%0d got=%h want=%h", i, DOut, (i == 15) ? PRID : 32'd0);
      end
    end
    checks++;
    if (req !== 1'b0 || EPCOut !== 32'd0) begin
      errors++;
      $display("FAIL reset_req_epc req=%b epc=%h want req=0 epc=0", req, EPCOut);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_interrupt();
    idle();
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; M_PC = 32'h0000_3010;
    #1;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL int_req got=%b want=1", req); end
    tick();
    HWInt = 6'd0;
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got=%h want=00000400", DOut); end
    A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_0403) begin errors++; $display("FAIL int_sr got=%h want=00000403", DOut); end
    checks++;
    if (EPCOut !== 32'h0000_3010) begin errors++; $display("FAIL int_epc got=%h want=00003010", EPCOut); end
    EXLClr = 1'b1; tick(); EXLClr = 1'b0;
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_exception();
    idle();
    M_ExcCode = 5'd10; M_isBD = 1'b1; M_PC = 32'h0000_3008;
    #1;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL exc_req got=%b want=1", req); end
    tick();
    A1 = 5'd13;
    M_ExcCode = 5'd12; M_isBD = 1'b0; M_PC = 32'h0000_300C;
    #1;
    checks++;
    if (EPCOut !== 32'h0000_3004) begin errors++; $display("FAIL exc_epc got=%h want=00003004", EPCOut); end
    checks++;
    if (DOut !== 32'h8000_0028) begin errors++; $display("FAIL exc_cause got=%h want=80000028", DOut); end
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL exc_nested_req got=%b want=0", req); end
    tick();
    checks++;
    if (DOut !== 32'h8000_0028 || EPCOut !== 32'h0000_3004) begin
      errors++;
      $display("FAIL exc_nested_hold cause=%h epc=%h want 80000028/00003004", DOut, EPCOut);
    end
    M_ExcCode = 5'd0; EXLClr = 1'b1; tick(); EXLClr = 1'b0;
    // EPC wraps modulo 2^32 for a delay-slot fault at PC 0.
    M_ExcCode = 5'd4; M_isBD = 1'b1; M_PC = 32'd0;
    tick();
    M_ExcCode = 5'd0; M_isBD = 1'b0;
    #1;
    checks++;
    if (EPCOut !== 32'hFFFF_FFFC) begin errors++; $display("FAIL exc_wrap got=%h want=fffffffc", EPCOut); end
    EXLClr = 1'b1; tick(); EXLClr = 1'b0;
  endtask

  task automatic test_priority();
    idle();
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; M_ExcCode = 5'd5; M_PC = 32'h0000_3020;
    WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEF;
    tick();
    WE = 1'b0; M_ExcCode = 5'd0;
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause got=%h want=00000400", DOut); end
    checks++;
    if (EPCOut !== 32'h0000_3020) begin errors++; $display("FAIL prio_epc_drop got=%h want=00003020", EPCOut); end
  endtask

  task automatic test_eret();
    // Entered with EXL=1 and an enabled interrupt still pending on HWInt[0].
    EXLClr = 1'b1;
    #1;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL eret_req_now got=%b want=0", req); end
    tick();
    EXLClr = 1'b0;
    #1;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL eret_req_next got=%b want=1", req); end
    checks++;
    if (EPCOut !== 32'h0000_3020) begin errors++; $display("FAIL eret_epc got=%h want=00003020", EPCOut); end
    HWInt = 6'd0; #1;
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0803; EXLClr = 1'b1;
    A1 = 5'd12;
    #1;
    checks++;
    if (DOut !== 32'h0000_0401) begin errors++; $display("FAIL rw_same_pre got=%h want=00000401", DOut); end
    tick();
    WE = 1'b0; EXLClr = 1'b0;
    #1;
    checks++;
    if (DOut !== 32'h0000_0801) begin errors++; $display("FAIL eret_mtc0_sr got=%h want=00000801", DOut); end
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_async_reset();
    idle();
    mtc0(5'd14, 32'h1234_5678);
    HWInt = 6'h3F;
    mtc0(5'd12, 32'h0000_FC03);
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    for (int i = 12; i <= 14; i++) begin
      A1 = 5'(i);
      #1;
      checks++;
      if (DOut !== 32'd0) begin errors++; $display("FAIL async_reset A1=%0d got=%h want=0", i, DOut); end
    end
    checks++;
    if (req !== 1'b0 || EPCOut !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_out req=%b epc=%h want 0/0", req, EPCOut);
    end
    reset = 1'b1;
    HWInt = 6'd0;
    tick();
  endtask

  task automatic test_random();
    int r;
    logic [4:0] idx_tab [5];
    idx_tab[0] = 5'd12; idx_tab[1] = 5'd13; idx_tab[2] = 5'd14; idx_tab[3] = 5'd15; idx_tab[4] = 5'd3;
    idle();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      WE = (r < 30);
      A2 = idx_tab[$urandom_range(0, 4)];
      DIn = $urandom();
      A1 = idx_tab[$urandom_range(0, 4)];
      M_PC = {$urandom_range(0, 65535), 2'b00} ;
      M_isBD = 1'($urandom_range(0, 1));
      M_ExcCode = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      EXLClr = ($urandom_range(0, 7) == 0);
      HWInt = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0;
      #1;
      checks++;
      if (req !== m_req() || DOut !== m_read(A1) || EPCOut !== m_epc) begin
        errors++;
        $display("FAIL random n=%0d req=%b/%b dout=%h/%h epc=%h/%h", n, req, m_req(),
                 DOut, m_read(A1), EPCOut, m_epc);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    m_clear();
    test_reset();
    test_interrupt();
    test_exception();
    test_priority();
    test_eret();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
